// File: rtl/roce_axis_width_adapter_if.sv
// AXI4-Stream bundle used on both sides of the RoCE width adapter.
interface roce_axis_width_adapter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 4
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [DEST_WIDTH-1:0]   tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tdest, output tready);
endinterface

// File: rtl/roce_axis_width_adapter.sv
// AXI4-Stream width adapter: pass-through, integer downsize with tail trimming,
// or integer upsize with tlast flush. Counts m-side packets.
module roce_axis_width_adapter #(
  parameter int S_DATA_WIDTH = 512,
  parameter int M_DATA_WIDTH = 64,
  parameter int DEST_WIDTH   = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      net_clk,
  input  logic                      net_aresetn,
  roce_axis_width_adapter_if.slave  s_axis,
  roce_axis_width_adapter_if.master m_axis,
  output logic [CNT_WIDTH-1:0]      pkt_count
);
  localparam int SK = S_DATA_WIDTH / 8;
  localparam int MK = M_DATA_WIDTH / 8;
  localparam int R  = (S_DATA_WIDTH > M_DATA_WIDTH) ? S_DATA_WIDTH / M_DATA_WIDTH
                                                    : M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  if (S_DATA_WIDTH % 8 != 0 || M_DATA_WIDTH % 8 != 0) begin : g_bad_bytes
    $error("roce_axis_width_adapter: data widths must be multiples of 8");
  end
  if (S_DATA_WIDTH % M_DATA_WIDTH != 0 && M_DATA_WIDTH % S_DATA_WIDTH != 0) begin : g_bad_ratio
    $error("roce_axis_width_adapter: widths must be integer multiples of each other");
  end
  if (DEST_WIDTH < 1) begin : g_bad_dest
    $error("roce_axis_width_adapter: DEST_WIDTH must be at least 1");
  end

  logic                    m_valid, m_last;
  logic [M_DATA_WIDTH-1:0] m_data;
  logic [MK-1:0]           m_keep;
  logic [DEST_WIDTH-1:0]   m_dest;

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdest  = m_dest;

  always_ff @(posedge net_clk) begin
    if (!net_aresetn)                         pkt_count <= '0;
    else if (m_valid && m_axis.tready && m_last) pkt_count <= pkt_count + 1'b1;
  end

  if (S_DATA_WIDTH == M_DATA_WIDTH) begin : g_pass
    assign s_axis.tready = net_aresetn && (!m_valid || m_axis.tready);

    always_ff @(posedge net_clk) begin
      if (!net_aresetn) begin
        m_valid <= 1'b0; m_data <= '0; m_keep <= '0; m_last <= 1'b0; m_dest <= '0;
      end else if (!m_valid || m_axis.tready) begin
        m_valid <= s_axis.tvalid;
        if (s_axis.tvalid) begin
          m_data <= s_axis.tdata; m_keep <= s_axis.tkeep;
          m_last <= s_axis.tlast; m_dest <= s_axis.tdest;
        end
      end
    end

  end else if (S_DATA_WIDTH > M_DATA_WIDTH) begin : g_down
    typedef enum logic {IDLE, EMIT} state_t;
    state_t                         state;
    logic [R-1:0][M_DATA_WIDTH-1:0] s_data, hold_data;
    logic [R-1:0][MK-1:0]           s_keep, hold_keep;
    logic                           hold_last, last_lane, s_hs;
    logic [IW-1:0]                  idx, nidx, top, s_top;

    assign s_data = s_axis.tdata;
    assign s_keep = s_axis.tkeep;

    // Highest lane carrying any byte; an empty beat still emits lane 0.
    always_comb begin
      s_top = '0;
      for (int i = 0; i < R; i++)
        if (|s_keep[i]) s_top = IW'(i);
    end

    assign nidx      = idx + 1'b1;
    assign last_lane = (idx == top);
    assign s_axis.tready = net_aresetn &&
                           (state == IDLE || (last_lane && m_axis.tready));
    assign s_hs = s_axis.tvalid && s_axis.tready;

    always_ff @(posedge net_clk) begin
      if (!net_aresetn) begin
        state <= IDLE; idx <= '0; top <= '0;
        hold_data <= '0; hold_keep <= '0; hold_last <= 1'b0;
        m_valid <= 1'b0; m_data <= '0; m_keep <= '0; m_last <= 1'b0; m_dest <= '0;
      end else if (s_hs) begin
        // Also covers reload on the final lane handshake, keeping back-to-back beats bubble-free.
        state     <= EMIT;
        hold_data <= s_data;
        hold_keep <= s_keep;
        hold_last <= s_axis.tlast;
        top       <= s_top;
        idx       <= '0;
        m_valid   <= 1'b1;
        m_data    <= s_data[0];
        m_keep    <= s_keep[0];
        m_last    <= s_axis.tlast && (s_top == '0);
        m_dest    <= s_axis.tdest;
      end else if (state == EMIT && m_axis.tready) begin
        if (last_lane) begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end else begin
          idx    <= nidx;
          m_data <= hold_data[nidx];
          m_keep <= hold_keep[nidx];
          m_last <= hold_last && (nidx == top);
        end
      end
    end

  end else begin : g_up
    logic [R-1:0][S_DATA_WIDTH-1:0] stage_data, nxt_data;
    logic [R-1:0][SK-1:0]           stage_keep, nxt_keep;
    logic [DEST_WIDTH-1:0]          stage_dest;
    logic [IW-1:0]                  b;
    logic                           s_hs, grp_done;

    assign s_axis.tready = net_aresetn && (!m_valid || m_axis.tready);
    assign s_hs     = s_axis.tvalid && s_axis.tready;
    assign grp_done = (b == IW'(R - 1)) || s_axis.tlast;

    // Staging is cleared on every completion, so lanes above b are already zero.
    always_comb begin
      nxt_data    = stage_data;
      nxt_keep    = stage_keep;
      nxt_data[b] = s_axis.tdata;
      nxt_keep[b] = s_axis.tkeep;
    end

    always_ff @(posedge net_clk) begin
      if (!net_aresetn) begin
        b <= '0; stage_data <= '0; stage_keep <= '0; stage_dest <= '0;
        m_valid <= 1'b0; m_data <= '0; m_keep <= '0; m_last <= 1'b0; m_dest <= '0;
      end else begin
        if (m_valid && m_axis.tready) m_valid <= 1'b0;
        if (s_hs) begin
          if (grp_done) begin
            m_valid    <= 1'b1;
            m_data     <= nxt_data;
            m_keep     <= nxt_keep;
            m_last     <= s_axis.tlast;
            m_dest     <= (b == '0) ? s_axis.tdest : stage_dest;
            stage_data <= '0;
            stage_keep <= '0;
            b          <= '0;
          end else begin
            stage_data <= nxt_data;
            stage_keep <= nxt_keep;
            b          <= b + 1'b1;
            if (b == '0) stage_dest <= s_axis.tdest;
          end
        end
      end
    end
  end
endmodule

// File: doc/roce_axis_width_adapter.md
Name: roce_axis_width_adapter

Overview:
Parametrised AXI4-Stream width adapter for the RoCE data paths: mem read data, tx data and mem write data. It is the successor to the fixed 512<->64 converter pair. It handles any integer up/down ratio, or equal width, in one block. It carries tdest through, trims trailing empty lanes on downsize, flushes partial groups on tlast during upsize, and counts packets. It sits between the rocev2 core ports and the DMA/role interfaces, on net_clk.

Parameters:
S_DATA_WIDTH, 512, input data width in bits; a multiple of 8.
M_DATA_WIDTH, 64, output data width in bits; a multiple of 8. One of S/M must divide the other.
DEST_WIDTH, 4, tdest width; minimum 1.
CNT_WIDTH, 32, packet counter width.

Ports:
net_clk  in  1  clock
net_aresetn  in  1  synchronous active-low reset, sampled on rising net_clk
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  S_DATA_WIDTH  input data
s_axis_tkeep  in  S_DATA_WIDTH/8  input byte enables, contiguous from byte 0
s_axis_tlast  in  1  end of packet
s_axis_tdest  in  DEST_WIDTH  destination, constant within a packet
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  M_DATA_WIDTH  output data
m_axis_tkeep  out  M_DATA_WIDTH/8  output byte enables
m_axis_tlast  out  1  end of packet
m_axis_tdest  out  DEST_WIDTH  destination
pkt_count  out  CNT_WIDTH  number of m-side tlast handshakes since reset

Behaviour:
- Reset (net_aresetn=0 at a clock edge): m_axis_tvalid=0, m_axis_tdata/tkeep/tdest=0, m_axis_tlast=0, pkt_count=0, all lane/beat counters=0. s_axis_tready=0 while net_aresetn=0. A beat in flight at reset is discarded; nothing is flushed.
- Handshakes follow AXI-S:
  - A transfer occurs when valid&&ready at the clock edge.
  - Once m_axis_tvalid=1, m payload stays stable until accepted.
  - s_axis_tready does not depend combinationally on s_axis_tvalid.
- Mode PASS (S==M):
  - Single register stage; latency 1.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, giving full throughput.
- Mode DOWN (R=S/M>1):
  - States IDLE and EMIT. In IDLE, an accepted beat is stored in a holding register.
  - Compute n = 1 + index of the highest lane (M-bit slice) with any keep bit set. If keep is all zero, n=1.
  - Go to EMIT with lane index 0 and m_axis_tvalid=1 on the next cycle (latency 1).
  - Each m handshake advances the lane index.
  - Lane i outputs slice i of data and keep, plus the stored tdest.
  - m_axis_tlast = stored last && (i==n-1).
  - After lane n-1 is accepted, return to IDLE. Lanes n..R-1 are never emitted.
  - s_axis_tready = IDLE || (EMIT && i==n-1 && m_axis_tready). A back-to-back input can load in the same cycle as the final lane handshake, so there is no bubble.
- Mode UP (R=M/S>1):
  - Beat counter b in 0..R-1.
  - An accepted beat writes data/keep into lane b of the staging register. On b==0 it also captures tdest.
  - The group completes when b==R-1 or s_axis_tlast=1.
  - On completion, m_axis_tvalid=1 on the next cycle, b resets to 0, and unfilled lanes have data=0, keep=0.
  - m_axis_tlast = tlast of the last written beat.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready. Staging for the new group may start in the same cycle the previous output is accepted.
  - Latency: 1 cycle after the completing beat.
  - Throughput: 1 output per R inputs, with no stalls when m_axis_tready=1.
- tdest handling:
  - DOWN mode holds the stored tdest for all lanes.
  - UP mode uses the first-beat tdest; a tdest change mid-group is ignored until the next group.
- pkt_count increments by 1 on each m_axis_tvalid&&m_axis_tready&&m_axis_tlast and wraps modulo 2^CNT_WIDTH.
- Backpressure: with m_axis_tready=0 held indefinitely, no data is lost or duplicated, and at most one input beat (DOWN) or one group (UP) is buffered.
- The configuration checks that S%M==0 or M%S==0 and that widths are multiples of 8; violating either is an elaboration error.

Test Plan:
- DOWN 512->64, one beat with keep=all 1s, last=1, data bytes 0x00..0x3F, dest=3 -> 8 m beats: data 0x0706..0100, 0x0F0E..0908, …; keep=0xFF each; last only on beat 8; dest=3 each; pkt_count=1.
- DOWN 512->64, keep=0x0000_0000_000F_FFFF (20 bytes), last=1 -> 3 m beats with keep 0xFF, 0xFF, 0x0F and last on the 3rd. Then keep=0 with last=1 -> 1 beat with keep=0x00 and last=1.
- UP 64->512, 3 beats with keep 0xFF, 0xFF, 0x03 and last on the 3rd, dest=5 -> 1 m beat with keep=0x0000_0000_0003_FFFF, upper data zero, last=1, dest=5; m_axis_tvalid rises 1 cycle after the 3rd beat.
- UP 64->512 streaming: 16 beats, valid held high, m_axis_tready=1, last on beat 16 -> 2 m beats, s_axis_tready never deasserts, second beat last=1.
- Backpressure in DOWN and UP modes: m_axis_tready toggled randomly (~50%) over 1000 random packets -> scoreboard byte stream, keep, last and dest all match; pkt_count=1000.
- Mid-packet reset: assert net_aresetn=0 for 1 cycle during DOWN EMIT at lane 3 -> next cycle m_axis_tvalid=0, pkt_count=0; a fresh packet after release is converted correctly.
